alu_seq: RTL

Parametrised, handshaked successor to the combinational ALU datapath: a WIDTH-bit ALU with the same nine opcodes and {V,Z,C,N} flag format. Adds variable shift/rotate amounts, a full-width product high word, illegal-opcode reporting and valid/ready flow control. The multiplier is iterative and optional. It sits between the register-file read stage and the write-back stage of the processor.

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: nine opcodes, {V,Z,C,N} flags, illegal-opcode reporting.
// Define ALU_MUL_EN to build the iterative shift-add multiplier; otherwise MUL reports err.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             err
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] result_reg, result_hi_reg;
    logic [3:0]       flags_reg;
    logic             err_reg;

    logic             accept, start_mul, mul_last;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] lsl_res, lsr_res, ror_res;
    logic             lsl_c, lsr_c;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;
    logic [3:0]       alu_flags;

    assign accept    = in_valid && (state_reg == S_IDLE);
    assign start_mul = MUL_EN && (op == OP_MUL);
    assign shamt     = in2[SHW-1:0];

    assign add_sum = {1'b0, in1} + {1'b0, in2};
    assign sub_sum = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};

    // One extra bit on the shifted vector catches the last bit shifted out (0 when shamt==0)
    assign {lsl_c, lsl_res} = {1'b0, in1} << shamt;
    assign {lsr_res, lsr_c} = {in1, 1'b0} >> shamt;
    assign ror_res          = (in1 >> shamt) | (in1 << (WIDTH - int'(shamt)));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_sum[WIDTH] ^ (add_sum[WIDTH-1] ^ in1[WIDTH-1] ^ in2[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = sub_sum[WIDTH] ^ (sub_sum[WIDTH-1] ^ in1[WIDTH-1] ^ ~in2[WIDTH-1]);
            end
            OP_OR:  alu_res = in1 | in2;
            OP_AND: alu_res = in1 & in2;
            OP_XOR: alu_res = in1 ^ in2;
            OP_LSL: begin
                alu_res = lsl_res;
                alu_c   = lsl_c;
            end
            OP_LSR: begin
                alu_res = lsr_res;
                alu_c   = lsr_c;
            end
            OP_ROR: begin
                alu_res = ror_res;
                alu_c   = lsr_c;
            end
            default: ;
        endcase
    end

    assign alu_err   = (op > OP_ROR) || ((op == OP_MUL) && !MUL_EN);
    assign alu_flags = alu_err ? 4'b0000 : {alu_v, (alu_res == '0), alu_c, alu_res[WIDTH-1]};

`ifdef ALU_MUL_EN
    // acc_reg holds {partial product high, remaining multiplier bits}; shifts right each cycle
    logic [2*WIDTH-1:0] acc_reg, acc_step;
    logic [WIDTH-1:0]   mcand_reg;
    logic [SHW-1:0]     cnt_reg;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   prod_lo, prod_hi;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    assign acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
    assign prod_lo  = acc_step[WIDTH-1:0];
    assign prod_hi  = acc_step[2*WIDTH-1:WIDTH];
    assign mul_last = (cnt_reg == SHW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            mcand_reg <= '0;
            cnt_reg   <= '0;
        end else if (accept && start_mul) begin
            acc_reg   <= {{WIDTH{1'b0}}, in2};
            mcand_reg <= in1;
            cnt_reg   <= '0;
        end else if (state_reg == S_MUL) begin
            acc_reg   <= acc_step;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end
`else
    assign mul_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg    <= '0;
            result_hi_reg <= '0;
            flags_reg     <= '0;
            err_reg       <= 1'b0;
        end else if (accept) begin
            err_reg <= alu_err;
            if (!start_mul) begin
                result_reg    <= alu_res;
                result_hi_reg <= '0;
                flags_reg     <= alu_flags;
            end
        end
`ifdef ALU_MUL_EN
        else if ((state_reg == S_MUL) && mul_last) begin
            result_reg    <= prod_lo;
            result_hi_reg <= prod_hi;
            flags_reg     <= {(prod_hi != '0), (prod_lo == '0), (prod_hi != '0), prod_lo[WIDTH-1]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (in_valid) state_next = start_mul ? S_MUL : S_DONE;
            S_MUL:  if (mul_last || !MUL_EN) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == S_IDLE);
        out_valid = (state_reg == S_DONE);
    end

    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign flags     = flags_reg;
    assign err       = err_reg;

endmodule
